// File: rtl/flash_arb_if.sv
// Bundle of the instruction-fetch, data-read and flash-reader handshake signals.
// The slave modport is the arbiter's view; master is the requester/flash side.
interface flash_arb_if;
  logic [31:0] wb_ibus_adr;
  logic        wb_ibus_cyc;
  logic [31:0] wb_ibus_rdt;
  logic        wb_ibus_ack;
  logic [31:0] wb_dbus_adr;
  logic        wb_dbus_cyc;
  logic [31:0] wb_dbus_rdt;
  logic        wb_dbus_ack;
  logic [31:0] wb_flash_adr;
  logic        wb_flash_cyc;
  logic [31:0] wb_flash_rdt;
  logic        wb_flash_ack;

  modport slave (
    input  wb_ibus_adr, wb_ibus_cyc, wb_dbus_adr, wb_dbus_cyc, wb_flash_rdt, wb_flash_ack,
    output wb_ibus_rdt, wb_ibus_ack, wb_dbus_rdt, wb_dbus_ack, wb_flash_adr, wb_flash_cyc
  );

  modport master (
    output wb_ibus_adr, wb_ibus_cyc, wb_dbus_adr, wb_dbus_cyc, wb_flash_rdt, wb_flash_ack,
    input  wb_ibus_rdt, wb_ibus_ack, wb_dbus_rdt, wb_dbus_ack, wb_flash_adr, wb_flash_cyc
  );
endinterface

// File: rtl/flash_arb.sv
// Round-robin arbiter sharing one SPI flash reader between ibus fetches and dbus reads.
// Optional grant watchdog enabled by defining FLASH_ARB_TIMEOUT_EN.
module flash_arb #(
  parameter int TIMEOUT = 1024
) (
  input  logic        wb_clk,
  input  logic        wb_rst,
  flash_arb_if.slave  bus,
  output logic        busy,
  output logic        timeout_err
);

  typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D, DONE} state_t;

  state_t      state_reg, state_next;
  logic        last_reg, last_next;          // 1: dbus was served last
  logic [31:0] flash_adr_reg, flash_adr_next;
  logic        flash_cyc_reg, flash_cyc_next;
  logic [31:0] ibus_rdt_reg, ibus_rdt_next;
  logic [31:0] dbus_rdt_reg, dbus_rdt_next;
  logic        ibus_ack_reg, ibus_ack_next;
  logic        dbus_ack_reg, dbus_ack_next;

  logic        req_cyc;
  logic        done_hit;
  logic [31:0] done_data;

`ifdef FLASH_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             terr_reg, terr_next;
`endif

  always_comb begin
    state_next     = state_reg;
    last_next      = last_reg;
    flash_adr_next = flash_adr_reg;
    flash_cyc_next = flash_cyc_reg;
    ibus_rdt_next  = ibus_rdt_reg;
    dbus_rdt_next  = dbus_rdt_reg;
    ibus_ack_next  = 1'b0;
    dbus_ack_next  = 1'b0;
    req_cyc        = 1'b0;
    done_hit       = 1'b0;
    done_data      = bus.wb_flash_rdt;
`ifdef FLASH_ARB_TIMEOUT_EN
    cnt_next       = cnt_reg;
    terr_next      = terr_reg;
`endif

    case (state_reg)
      IDLE: begin
        // On a tie the requester not served last wins.
        if (bus.wb_ibus_cyc && (!bus.wb_dbus_cyc || last_reg)) begin
          state_next     = GRANT_I;
          last_next      = 1'b0;
          flash_adr_next = bus.wb_ibus_adr;
          flash_cyc_next = 1'b1;
`ifdef FLASH_ARB_TIMEOUT_EN
          cnt_next       = '0;
`endif
        end else if (bus.wb_dbus_cyc) begin
          state_next     = GRANT_D;
          last_next      = 1'b1;
          flash_adr_next = bus.wb_dbus_adr;
          flash_cyc_next = 1'b1;
`ifdef FLASH_ARB_TIMEOUT_EN
          cnt_next       = '0;
`endif
        end
      end
      GRANT_I, GRANT_D: begin
        req_cyc = (state_reg == GRANT_I) ? bus.wb_ibus_cyc : bus.wb_dbus_cyc;
        // An abort takes priority over a flash ack arriving in the same cycle.
        if (!req_cyc) begin
          state_next     = IDLE;
          flash_cyc_next = 1'b0;
        end else if (bus.wb_flash_ack) begin
          done_hit = 1'b1;
        end
`ifdef FLASH_ARB_TIMEOUT_EN
        else if (cnt_reg == CNT_W'(TIMEOUT - 1)) begin
          done_hit  = 1'b1;
          done_data = 32'hFFFF_FFFF;
          terr_next = 1'b1;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
`endif
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase

    if (done_hit) begin
      state_next     = DONE;
      flash_cyc_next = 1'b0;
      if (state_reg == GRANT_I) begin
        ibus_rdt_next = done_data;
        ibus_ack_next = 1'b1;
      end else begin
        dbus_rdt_next = done_data;
        dbus_ack_next = 1'b1;
      end
    end
  end

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      state_reg     <= IDLE;
      last_reg      <= 1'b1;
      flash_adr_reg <= '0;
      flash_cyc_reg <= 1'b0;
      ibus_rdt_reg  <= '0;
      dbus_rdt_reg  <= '0;
      ibus_ack_reg  <= 1'b0;
      dbus_ack_reg  <= 1'b0;
`ifdef FLASH_ARB_TIMEOUT_EN
      cnt_reg       <= '0;
      terr_reg      <= 1'b0;
`endif
    end else begin
      state_reg     <= state_next;
      last_reg      <= last_next;
      flash_adr_reg <= flash_adr_next;
      flash_cyc_reg <= flash_cyc_next;
      ibus_rdt_reg  <= ibus_rdt_next;
      dbus_rdt_reg  <= dbus_rdt_next;
      ibus_ack_reg  <= ibus_ack_next;
      dbus_ack_reg  <= dbus_ack_next;
`ifdef FLASH_ARB_TIMEOUT_EN
      cnt_reg       <= cnt_next;
      terr_reg      <= terr_next;
`endif
    end
  end

  assign bus.wb_flash_adr = flash_adr_reg;
  assign bus.wb_flash_cyc = flash_cyc_reg;
  assign bus.wb_ibus_rdt  = ibus_rdt_reg;
  assign bus.wb_ibus_ack  = ibus_ack_reg;
  assign bus.wb_dbus_rdt  = dbus_rdt_reg;
  assign bus.wb_dbus_ack  = dbus_ack_reg;
  assign busy             = (state_reg != IDLE);

`ifdef FLASH_ARB_TIMEOUT_EN
  assign timeout_err = terr_reg;
`else
  assign timeout_err = 1'b0 & (TIMEOUT == 0);
`endif

endmodule
